// File: rtl/lifo_stack_pkg.sv
// Shared types for the parametrised LIFO stack: operation encoding and
// the width helper used to size the occupancy count.
package lifo_stack_pkg;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_CLEAR
  } op_e;

  // Bits needed to hold every value 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lifo_stack_mem.sv
// Register-array storage for the stack: one synchronous write port and one
// asynchronous read port. Contents are deliberately left unreset.
module lifo_stack_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with peek output, same-cycle replace of the top,
// sticky overflow/underflow flags, occupancy count and synchronous clear.
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 16,
  parameter  int AF_LEVEL = DEPTH - 2,
  localparam int CW       = count_width(DEPTH)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  op_e              op;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    top_addr;
  logic [WIDTH-1:0] rdata;
  logic             is_empty;
  logic             is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign top_addr = AW'(count_q - CW'(1));

  // A push+pop on an empty stack has no top to replace, so it decays to a push.
  always_comb begin
    op = OP_NONE;
    if (clear) begin
      op = OP_CLEAR;
    end else if (push && pop && !is_empty) begin
      op = OP_REPLACE;
    end else if (push) begin
      op = OP_PUSH;
    end else if (pop) begin
      op = OP_POP;
    end
  end

  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    we          = 1'b0;
    waddr       = AW'(count_q);
    case (op)
      OP_CLEAR: begin
        count_d     = '0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
      end
      OP_REPLACE: begin
        we    = 1'b1;
        waddr = top_addr;
      end
      OP_PUSH: begin
        if (is_full) begin
          overflow_d = 1'b1;
        end else begin
          we      = 1'b1;
          count_d = count_q + CW'(1);
        end
      end
      OP_POP: begin
        if (is_empty) begin
          underflow_d = 1'b1;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  lifo_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (Clk),
    .we    (we),
    .waddr (waddr),
    .wdata (data_i),
    .raddr (top_addr),
    .rdata (rdata)
  );

  // Outputs depend only on registered state; the read port is masked when empty.
  assign data_o      = is_empty ? '0 : rdata;
  assign empty       = is_empty;
  assign full        = is_full;
  assign almost_full = (count_q >= CW'(AF_LEVEL));
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_lifo_stack.sv
// Directed self-checking bench for lifo_stack (WIDTH=8, DEPTH=16, AF_LEVEL=14):
// a vector table for the basic sequence plus hand-written corner cases.
module tb_lifo_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic             Clk;
  logic             Rst;
  logic             push;
  logic             pop;
  logic             clear;
  logic [WIDTH-1:0] data_i;
  logic [WIDTH-1:0] data_o;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  int checks;
  int failures;

  typedef struct {
    logic             push;
    logic             pop;
    logic             clear;
    logic [WIDTH-1:0] data;
    logic [CW-1:0]    exp_count;
    logic [WIDTH-1:0] exp_data;
    logic             exp_empty;
    logic             exp_full;
    logic             exp_af;
    logic             exp_ovf;
    logic             exp_udf;
  } vec_t;

  vec_t vecs [16];

  lifo_stack #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (14)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .push        (push),
    .pop         (pop),
    .clear       (clear),
    .data_i      (data_i),
    .data_o      (data_o),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Drive one cycle's strobes away from the edge, then sample 1 ns after it.
  task automatic applyStimulus(input logic p, input logic q, input logic c,
                               input logic [WIDTH-1:0] d);
    @(negedge Clk);
    push   = p;
    pop    = q;
    clear  = c;
    data_i = d;
    @(posedge Clk);
    #1;
    push  = 1'b0;
    pop   = 1'b0;
    clear = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [CW-1:0] ec,
                             input logic [WIDTH-1:0] ed, input logic ee,
                             input logic ef, input logic eaf, input logic eov,
                             input logic eud);
    logic [CW+WIDTH+4:0] act;
    logic [CW+WIDTH+4:0] exp;
    act = {count, data_o, empty, full, almost_full, overflow, underflow};
    exp = {ec, ed, ee, ef, eaf, eov, eud};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got count=%0d data=%h e=%b f=%b af=%b ov=%b ud=%b, want count=%0d data=%h e=%b f=%b af=%b ov=%b ud=%b",
               name, count, data_o, empty, full, almost_full, overflow, underflow,
               ec, ed, ee, ef, eaf, eov, eud);
    end
  endtask

  task automatic fillStack(input logic [WIDTH-1:0] base, input string name);
    logic [CW-1:0] n;
    for (int i = 0; i < DEPTH; i++) begin
      n = CW'(i + 1);
      applyStimulus(1'b1, 1'b0, 1'b0, base + WIDTH'(i));
      checkOutput(name, n, base + WIDTH'(i), 1'b0, (i + 1) == DEPTH,
                  (i + 1) >= 14, 1'b0, 1'b0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Rst      = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    clear    = 1'b0;
    data_i   = '0;

    //            push  pop   clr   data   cnt  data   e     f     af    ov    ud
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h01, 5'd1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h02, 5'd2, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h03, 5'd3, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd2, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 8'hEE, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h05, 5'd1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h06, 5'd2, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 8'h09, 5'd2, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 8'h07, 5'd1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 8'h99, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (2) @(posedge Clk);
    #1;
    checkOutput("reset_state", 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    Rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].push, vecs[i].pop, vecs[i].clear, vecs[i].data);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_data,
                  vecs[i].exp_empty, vecs[i].exp_full, vecs[i].exp_af,
                  vecs[i].exp_ovf, vecs[i].exp_udf);
    end

    // Fill to full, then a dropped push must set the sticky overflow flag.
    fillStack(8'h10, "fill_a");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hAA);
    checkOutput("push_when_full", 5'd16, 8'h1F, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("overflow_sticky", 5'd16, 8'h1F, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("pop_from_full", 5'd15, 8'h1E, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("clear_overflow", 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Replace while full must not overflow.
    fillStack(8'h30, "fill_b");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h55);
    checkOutput("replace_full", 5'd16, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("pop_after_replace", 5'd15, 8'h3E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("clear_b", 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges empties the stack without a clock.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h60 + 8'(i));
    end
    checkOutput("count_four", 5'd4, 8'h63, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    #2;
    Rst = 1'b0;
    #1;
    checkOutput("async_reset", 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    Rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h42);
    checkOutput("push_after_reset", 5'd1, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
